// File: rtl/dds_cfg_loader.sv
// Parses 7-byte framed writes (A5, ADDR, D3..D0, CHK) into the DDS control words; the word and cfg_update
// appear one cycle after the CHK byte. There is no backpressure: every rx_valid byte is consumed on arrival.
module dds_cfg_loader #(
    parameter int          TIMEOUT_CYC   = 50000,
    parameter logic [31:0] FREQ_DEFAULT  = 32'd85899,
    parameter logic [31:0] PHASE_DEFAULT = 32'd0,
    parameter logic [31:0] AMP_DEFAULT   = 32'h0000_00FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] freq_word,
    output logic [31:0] phase_word,
    output logic [31:0] amp_word,
    output logic [1:0]  wave_sel,
    output logic        cfg_update,
    output logic        frame_err,
    output logic        busy
);

    localparam int          GW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  HDR      = 8'hA5;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CHK} state_t;

    state_t        state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    xor_q, xor_d;
    logic [31:0]   hold_q, hold_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0]   freq_q, freq_d;
    logic [31:0]   phase_q, phase_d;
    logic [31:0]   amp_q, amp_d;
    logic [1:0]    wave_q, wave_d;
    logic          upd_q, upd_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          timeout;
    logic          frame_ok;

    // A byte landing on the final gap cycle wins over the timeout.
    assign timeout  = (state_q != S_IDLE) && !rx_valid && (gap_q == GAP_LAST);
    assign frame_ok = (rx_data == xor_q) && (addr_q >= 8'h01) && (addr_q <= 8'h04);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = S_IDLE;
        end else if (rx_valid) begin
            case (state_q)
                S_IDLE:  if (rx_data == HDR) state_d = S_ADDR;
                S_ADDR:  state_d = S_DATA;
                S_DATA:  if (cnt_q == 2'd3) state_d = S_CHK;
                S_CHK:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        addr_d  = addr_q;
        xor_d   = xor_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        freq_d  = freq_q;
        phase_d = phase_q;
        amp_d   = amp_q;
        wave_d  = wave_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        gap_d   = (state_q == S_IDLE || rx_valid || timeout) ? '0 : gap_q + 1'b1;
        busy_d  = (state_d != S_IDLE);
        if (timeout) begin
            err_d = 1'b1;
        end else if (rx_valid) begin
            case (state_q)
                S_ADDR: begin
                    addr_d = rx_data;
                    xor_d  = rx_data;
                    cnt_d  = 2'd0;
                end
                S_DATA: begin
                    hold_d = {hold_q[23:0], rx_data};
                    xor_d  = xor_q ^ rx_data;
                    cnt_d  = cnt_q + 2'd1;
                end
                S_CHK: begin
                    if (frame_ok) begin
                        upd_d = 1'b1;
                        case (addr_q)
                            8'h01:   freq_d  = hold_q;
                            8'h02:   phase_d = hold_q;
                            8'h03:   amp_d   = hold_q;
                            default: wave_d  = hold_q[1:0];
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            xor_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            freq_q  <= FREQ_DEFAULT;
            phase_q <= PHASE_DEFAULT;
            amp_q   <= AMP_DEFAULT;
            wave_q  <= 2'd0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            xor_q   <= xor_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            freq_q  <= freq_d;
            phase_q <= phase_d;
            amp_q   <= amp_d;
            wave_q  <= wave_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign freq_word  = freq_q;
    assign phase_word = phase_q;
    assign amp_word   = amp_q;
    assign wave_sel   = wave_q;
    assign cfg_update = upd_q;
    assign frame_err  = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dds_cfg_loader.sv
// Directed frames against dds_cfg_loader; a queue of expected pulse events is compared as pulses appear.
module tb_dds_cfg_loader;

    localparam logic [31:0] F_DEF = 32'd85899;
    localparam logic [31:0] P_DEF = 32'd0;
    localparam logic [31:0] A_DEF = 32'h0000_00FF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] freq_word, phase_word, amp_word;
    logic [1:0]  wave_sel;
    logic        cfg_update, frame_err, busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        is_err;
        logic [31:0] f;
        logic [31:0] p;
        logic [31:0] a;
        logic [1:0]  w;
    } ev_t;

    ev_t         evq[$];
    logic [31:0] m_freq = F_DEF, m_phase = P_DEF, m_amp = A_DEF;
    logic [1:0]  m_wave = 2'd0;

    dds_cfg_loader #(.TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .freq_word  (freq_word),
        .phase_word (phase_word),
        .amp_word   (amp_word),
        .wave_sel   (wave_sel),
        .cfg_update (cfg_update),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input logic is_err);
        ev_t e;
        e.is_err = is_err;
        e.f = m_freq;
        e.p = m_phase;
        e.a = m_amp;
        e.w = m_wave;
        evq.push_back(e);
    endtask

    // Reference decode of a full 7-byte frame into the expected event.
    task automatic push_frame(input logic [55:0] f);
        logic [7:0]  addr;
        logic [31:0] d;
        logic [7:0]  x;
        addr = f[47:40];
        d    = f[39:8];
        x    = addr ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
        if (x == f[7:0] && addr == 8'h01)      begin m_freq  = d;      push_ev(1'b0); end
        else if (x == f[7:0] && addr == 8'h02) begin m_phase = d;      push_ev(1'b0); end
        else if (x == f[7:0] && addr == 8'h03) begin m_amp   = d;      push_ev(1'b0); end
        else if (x == f[7:0] && addr == 8'h04) begin m_wave  = d[1:0]; push_ev(1'b0); end
        else push_ev(1'b1);
    endtask

    // Starts and ends on a negedge; on return rx_valid is low and the last byte was sampled one edge ago.
    task automatic send(input logic [55:0] f, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            rx_data  = f[55-8*i -: 8];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            if (i < n - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic check_words(input string tag);
        check({tag, "_freq"},  freq_word,  m_freq);
        check({tag, "_phase"}, phase_word, m_phase);
        check({tag, "_amp"},   amp_word,   m_amp);
        check({tag, "_wave"},  {30'd0, wave_sel}, {30'd0, m_wave});
    endtask

    always @(negedge clk) begin
        if (!rst && (cfg_update || frame_err)) begin
            total++;
            assert (evq.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_pulse observed=upd%0b/err%0b expected=none", cfg_update, frame_err);
            end
            if (evq.size() != 0) begin
                ev_t e;
                e = evq.pop_front();
                check("ev_err", {31'd0, frame_err},  {31'd0, e.is_err});
                check("ev_upd", {31'd0, cfg_update}, {31'd0, ~e.is_err});
                check("ev_freq",  freq_word,  e.f);
                check("ev_phase", phase_word, e.p);
                check("ev_amp",   amp_word,   e.a);
                check("ev_wave",  {30'd0, wave_sel}, {30'd0, e.w});
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_words("reset");
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_upd",  {31'd0, cfg_update}, 32'd0);
        check("reset_err",  {31'd0, frame_err}, 32'd0);

        // Back-to-back frequency write.
        push_frame(56'hA5_01_00_01_4F_8B_C4);
        send(56'hA5_01_00_01_4F_8B_C4, 7, 0);
        check("freq_upd_lat", {31'd0, cfg_update}, 32'd1);
        check("freq_busy_fall", {31'd0, busy}, 32'd0);
        check("freq_val", freq_word, 32'h0001_4F8B);
        check("freq_phase_hold", phase_word, P_DEF);
        check("freq_amp_hold", amp_word, A_DEF);
        @(negedge clk);
        check("freq_upd_one", {31'd0, cfg_update}, 32'd0);

        // Garbage before a header, spaced bytes.
        send({8'h00, 8'hFF, 40'd0}, 2, 10);
        repeat (3) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        push_frame(56'hA5_02_40_00_00_00_42);
        send(56'hA5_02_40_00_00_00_42, 7, 10);
        check("phase_upd", {31'd0, cfg_update}, 32'd1);
        check("phase_val", phase_word, 32'h4000_0000);
        @(negedge clk);

        // Bad checksum, then bad address.
        push_frame(56'hA5_03_00_00_00_80_00);
        send(56'hA5_03_00_00_00_80_00, 7, 0);
        check("badchk_err", {31'd0, frame_err}, 32'd1);
        check("badchk_amp", amp_word, 32'h0000_00FF);
        @(negedge clk);
        push_frame(56'hA5_07_00_00_00_01_06);
        send(56'hA5_07_00_00_00_01_06, 7, 0);
        check("badaddr_err", {31'd0, frame_err}, 32'd1);
        check_words("badaddr");
        @(negedge clk);

        // Timeout after a partial frame.
        push_ev(1'b1);
        send({24'hA5_01_12, 32'd0}, 3, 0);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 15) check("to_busy_before", {31'd0, busy}, 32'd1);
            if (frame_err) begin
                n = i;
                break;
            end
        end
        check("to_cycles", n, 32'd16);
        check("to_busy_after", {31'd0, busy}, 32'd0);
        @(negedge clk);
        push_frame(56'hA5_04_00_00_00_03_07);
        send(56'hA5_04_00_00_00_03_07, 7, 0);
        check("wave_val", {30'd0, wave_sel}, 32'd3);
        @(negedge clk);

        // Reset mid-frame.
        send({24'hA5_01_00, 32'd0}, 3, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_freq = F_DEF; m_phase = P_DEF; m_amp = A_DEF; m_wave = 2'd0;
        check_words("rst_mid");
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        send({32'h01_4F_8B_C4, 24'd0}, 4, 0);
        check("rst_tail_busy", {31'd0, busy}, 32'd0);
        check("rst_tail_freq", freq_word, F_DEF);
        repeat (2) @(negedge clk);
        push_frame(56'hA5_01_00_01_4F_8B_C4);
        send(56'hA5_01_00_01_4F_8B_C4, 7, 0);
        check("fresh_upd", {31'd0, cfg_update}, 32'd1);
        check("fresh_freq", freq_word, 32'h0001_4F8B);
        repeat (3) @(negedge clk);

        check("queue_empty", evq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
